// File: rtl/ldst_mem_pkg.sv
// Shared encodings and helpers for the load/store memory-access stage.
package ldst_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WB
  } state_e;

  function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned_f = 1'b0;
      SZ_HALF: misaligned_f = lo[0];
      SZ_WORD: misaligned_f = (lo != 2'b00);
      default: misaligned_f = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] strobe_f(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: strobe_f = 4'b0001 << lo;
      SZ_HALF: strobe_f = 4'b0011 << lo;
      default: strobe_f = 4'b1111;
    endcase
  endfunction

  // Replicate the store value across every lane it could land in.
  function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: wdata_f = {4{data[7:0]}};
      SZ_HALF: wdata_f = {2{data[15:0]}};
      default: wdata_f = data;
    endcase
  endfunction

endpackage

// File: rtl/ldst_mem_access_load_align.sv
// Lane select plus sign/zero extension of a returned load word.
module ldst_load_align
  import ldst_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{lo_i, 3'b000} +: 8];
    half_v = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{sign_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ldst_mem_access.sv
// Memory-access stage: effective address, data-memory handshake, load writeback.
// state      | meaning
// ST_IDLE    | sample requests, raise misalign on bad size/alignment
// ST_RD_REQ  | one-cycle read request
// ST_RD_WAIT | wait for rvalid, timer running
// ST_WR_REQ  | hold write until wready, timer running
// ST_WB      | one-cycle GPR writeback (suppressed for x0)
module ldst_mem_access
  import ldst_mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             risc_clk,
  input  logic             risc_rst,
  input  logic             ld_valid_i,
  input  logic             st_valid_i,
  input  logic [WIDTH-1:0] base_addr_i,
  input  logic [11:0]      offset_i,
  input  logic [1:0]       size_i,
  input  logic             sign_bit_i,
  input  logic [WIDTH-1:0] store_data_i,
  input  logic [4:0]       rd_addr_i,
  output logic             data_mem_read_en_o,
  output logic [WIDTH-1:0] data_mem_read_addr_o,
  input  logic [WIDTH-1:0] data_mem_read_data_i,
  input  logic             data_mem_rvalid_i,
  output logic             data_mem_write_en_o,
  output logic [WIDTH-1:0] data_mem_write_addr_o,
  output logic [WIDTH-1:0] data_mem_write_data_o,
  output logic [3:0]       data_mem_strobe_o,
  input  logic             data_mem_wready_i,
  output logic             reg_wr_en_o,
  output logic [4:0]       reg_wr_addr_o,
  output logic [WIDTH-1:0] reg_wr_data_o,
  output logic             stall_pipeline_o,
  output logic             misalign_exc_o,
  output logic             bus_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   ea, aligned;
  logic               accept, capture, misalign_d, bus_err_d;
  logic               stall_q, misalign_q, bus_err_q;
  logic [WIDTH-1:0]   addr_q, wdata_q, wb_q;
  logic [3:0]         strb_q;
  logic [1:0]         lo_q, size_q;
  logic               sign_q;
  logic [4:0]         rd_q;

  assign ea = base_addr_i + {{(WIDTH-12){offset_i[11]}}, offset_i};

  ldst_load_align u_align (
    .rdata_i (data_mem_read_data_i),
    .lo_i    (lo_q),
    .size_i  (size_q),
    .sign_i  (sign_q),
    .data_o  (aligned)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (st_valid_i || ld_valid_i) begin
          accept = 1'b1;
          if (misaligned_f(size_i, ea[1:0])) begin
            misalign_d = 1'b1;
          end else if (st_valid_i) begin
            state_d = ST_WR_REQ;
            cnt_d   = CW'(TIMEOUT - 1);
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
        cnt_d   = CW'(TIMEOUT - 1);
      end
      ST_RD_WAIT: begin
        if (data_mem_rvalid_i) begin
          capture = 1'b1;
          state_d = ST_WB;
        end else if (cnt_q == '0) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (data_mem_wready_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge risc_clk or posedge risc_rst) begin
    if (risc_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stall_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      lo_q       <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      rd_q       <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_q    <= (state_d != ST_IDLE);
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      if (accept) begin
        addr_q  <= {ea[WIDTH-1:2], 2'b00};
        wdata_q <= wdata_f(size_i, store_data_i);
        strb_q  <= strobe_f(size_i, ea[1:0]);
        lo_q    <= ea[1:0];
        size_q  <= size_i;
        sign_q  <= sign_bit_i;
        rd_q    <= rd_addr_i;
      end
      if (capture) wb_q <= aligned;
    end
  end

  assign data_mem_read_en_o    = (state_q == ST_RD_REQ);
  assign data_mem_read_addr_o  = addr_q;
  assign data_mem_write_en_o   = (state_q == ST_WR_REQ);
  assign data_mem_write_addr_o = addr_q;
  assign data_mem_write_data_o = wdata_q;
  assign data_mem_strobe_o     = strb_q;
  assign reg_wr_en_o           = (state_q == ST_WB) && (rd_q != 5'd0);
  assign reg_wr_addr_o         = rd_q;
  assign reg_wr_data_o         = wb_q;
  assign stall_pipeline_o      = stall_q;
  assign misalign_exc_o        = misalign_q;
  assign bus_err_o             = bus_err_q;

endmodule

// File: tb/tb_ldst_mem_access.sv
// Directed bench for ldst_mem_access; outputs sampled on the falling edge.
module tb_ldst_mem_access;

  logic        risc_clk = 1'b0;
  logic        risc_rst = 1'b1;
  logic        ld_valid_i = 1'b0, st_valid_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [11:0] offset_i = '0;
  logic [1:0]  size_i = '0;
  logic        sign_bit_i = 1'b0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        data_mem_read_en_o;
  logic [31:0] data_mem_read_addr_o;
  logic [31:0] data_mem_read_data_i = '0;
  logic        data_mem_rvalid_i = 1'b0;
  logic        data_mem_write_en_o;
  logic [31:0] data_mem_write_addr_o, data_mem_write_data_o;
  logic [3:0]  data_mem_strobe_o;
  logic        data_mem_wready_i = 1'b0;
  logic        reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;
  logic        stall_pipeline_o, misalign_exc_o, bus_err_o;

  int checks = 0;
  int failures = 0;

  always #5 risc_clk = ~risc_clk;

  ldst_mem_access #(.WIDTH(32), .TIMEOUT(16)) dut (
    .risc_clk(risc_clk), .risc_rst(risc_rst),
    .ld_valid_i(ld_valid_i), .st_valid_i(st_valid_i),
    .base_addr_i(base_addr_i), .offset_i(offset_i), .size_i(size_i),
    .sign_bit_i(sign_bit_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
    .data_mem_read_en_o(data_mem_read_en_o), .data_mem_read_addr_o(data_mem_read_addr_o),
    .data_mem_read_data_i(data_mem_read_data_i), .data_mem_rvalid_i(data_mem_rvalid_i),
    .data_mem_write_en_o(data_mem_write_en_o), .data_mem_write_addr_o(data_mem_write_addr_o),
    .data_mem_write_data_o(data_mem_write_data_o), .data_mem_strobe_o(data_mem_strobe_o),
    .data_mem_wready_i(data_mem_wready_i),
    .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o), .reg_wr_data_o(reg_wr_data_o),
    .stall_pipeline_o(stall_pipeline_o), .misalign_exc_o(misalign_exc_o), .bus_err_o(bus_err_o)
  );

  // Upstream contract: a request raised while stalled is held into the next cycle.
  assert property (@(posedge risc_clk) disable iff (risc_rst)
    (stall_pipeline_o && (ld_valid_i || st_valid_i)) |=> (ld_valid_i || st_valid_i))
    else $error("request dropped while stalled");

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic ld, input logic st, input logic [31:0] base,
                     input logic [11:0] off, input logic [1:0] sz, input logic sgn,
                     input logic [31:0] sdata, input logic [4:0] rd);
    ld_valid_i = ld; st_valid_i = st; base_addr_i = base; offset_i = off;
    size_i = sz; sign_bit_i = sgn; store_data_i = sdata; rd_addr_i = rd;
  endtask

  task automatic drop_req();
    ld_valid_i = 1'b0; st_valid_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_stall", 32'(stall_pipeline_o), 0);
    chk("rst_rd_en", 32'(data_mem_read_en_o), 0);
    chk("rst_wr_en", 32'(data_mem_write_en_o), 0);
    chk("rst_reg_wr", 32'(reg_wr_en_o), 0);
    @(negedge risc_clk); risc_rst = 1'b0;
    @(negedge risc_clk);

    // Reset during RD_WAIT
    req(1, 0, 32'h1000, 12'h000, 2'b10, 0, 0, 5'd9);
    @(negedge risc_clk); drop_req();
    chk("mid_rd_en", 32'(data_mem_read_en_o), 1);
    @(negedge risc_clk);
    chk("mid_wait_stall", 32'(stall_pipeline_o), 1);
    #1 risc_rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall_pipeline_o), 0);
    chk("mid_rst_raddr", data_mem_read_addr_o, 0);
    chk("mid_rst_reg_wr", 32'(reg_wr_en_o), 0);
    @(negedge risc_clk); risc_rst = 1'b0;
    data_mem_rvalid_i = 1'b1; data_mem_read_data_i = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge risc_clk);
      chk("mid_rst_no_wb", 32'(reg_wr_en_o), 0);
      chk("mid_rst_idle", 32'(stall_pipeline_o), 0);
    end
    data_mem_rvalid_i = 1'b0;

    // Signed byte load from ea 0x1003
    req(1, 0, 32'h1000, 12'h003, 2'b00, 1, 0, 5'd5);
    @(negedge risc_clk); drop_req();
    chk("lbs_rd_en", 32'(data_mem_read_en_o), 1);
    chk("lbs_raddr", data_mem_read_addr_o, 32'h1000);
    chk("lbs_stall", 32'(stall_pipeline_o), 1);
    @(negedge risc_clk);
    chk("lbs_rd_en_pulse", 32'(data_mem_read_en_o), 0);
    data_mem_rvalid_i = 1'b1; data_mem_read_data_i = 32'h80FF_1234;
    @(negedge risc_clk); data_mem_rvalid_i = 1'b0;
    chk("lbs_wb_en", 32'(reg_wr_en_o), 1);
    chk("lbs_wb_addr", 32'(reg_wr_addr_o), 5);
    chk("lbs_wb_data", reg_wr_data_o, 32'hFFFF_FF80);
    @(negedge risc_clk);
    chk("lbs_wb_pulse", 32'(reg_wr_en_o), 0);
    chk("lbs_stall_end", 32'(stall_pipeline_o), 0);

    // Unsigned byte load, same address
    req(1, 0, 32'h1000, 12'h003, 2'b00, 0, 0, 5'd5);
    @(negedge risc_clk); drop_req();
    @(negedge risc_clk);
    data_mem_rvalid_i = 1'b1; data_mem_read_data_i = 32'h80FF_1234;
    @(negedge risc_clk); data_mem_rvalid_i = 1'b0;
    chk("lbu_wb_en", 32'(reg_wr_en_o), 1);
    chk("lbu_wb_data", reg_wr_data_o, 32'h0000_0080);
    @(negedge risc_clk);

    // Store half at ea 0x1FFE, wready in the third cycle
    req(0, 1, 32'h2000, 12'hFFE, 2'b01, 0, 32'hDEAD_BEEF, 5'd0);
    @(negedge risc_clk); drop_req();
    for (int i = 0; i < 3; i++) begin
      chk("sh_wr_en", 32'(data_mem_write_en_o), 1);
      chk("sh_waddr", data_mem_write_addr_o, 32'h1FFC);
      chk("sh_strobe", 32'(data_mem_strobe_o), 32'hC);
      chk("sh_wdata", data_mem_write_data_o, 32'hBEEF_BEEF);
      if (i == 2) data_mem_wready_i = 1'b1;
      @(negedge risc_clk);
    end
    data_mem_wready_i = 1'b0;
    chk("sh_wr_done", 32'(data_mem_write_en_o), 0);
    chk("sh_stall_end", 32'(stall_pipeline_o), 0);

    // Misaligned word load at ea 0x1002
    req(1, 0, 32'h1000, 12'h002, 2'b10, 0, 0, 5'd3);
    @(negedge risc_clk); drop_req();
    chk("mis_exc", 32'(misalign_exc_o), 1);
    chk("mis_no_rd", 32'(data_mem_read_en_o), 0);
    chk("mis_stall", 32'(stall_pipeline_o), 0);
    @(negedge risc_clk);
    chk("mis_exc_pulse", 32'(misalign_exc_o), 0);
    chk("mis_no_rd2", 32'(data_mem_read_en_o), 0);

    // Read timeout: 16 RD_WAIT cycles, then bus error
    req(1, 0, 32'h1000, 12'h000, 2'b10, 0, 0, 5'd4);
    @(negedge risc_clk); drop_req();
    for (int i = 1; i <= 17; i++) begin
      chk("to_waiting_stall", 32'(stall_pipeline_o), 1);
      chk("to_waiting_err", 32'(bus_err_o), 0);
      @(negedge risc_clk);
    end
    chk("to_bus_err", 32'(bus_err_o), 1);
    chk("to_stall_end", 32'(stall_pipeline_o), 0);
    chk("to_no_wb", 32'(reg_wr_en_o), 0);
    @(negedge risc_clk);
    chk("to_err_pulse", 32'(bus_err_o), 0);
    chk("to_no_wb2", 32'(reg_wr_en_o), 0);

    // Both valids: store wins, load dropped
    req(1, 1, 32'h3000, 12'h004, 2'b10, 0, 32'h1234_5678, 5'd7);
    @(negedge risc_clk); drop_req();
    chk("both_wr_en", 32'(data_mem_write_en_o), 1);
    chk("both_no_rd", 32'(data_mem_read_en_o), 0);
    chk("both_waddr", data_mem_write_addr_o, 32'h3004);
    chk("both_strobe", 32'(data_mem_strobe_o), 32'hF);
    chk("both_wdata", data_mem_write_data_o, 32'h1234_5678);
    data_mem_wready_i = 1'b1;
    @(negedge risc_clk); data_mem_wready_i = 1'b0;
    chk("both_wr_done", 32'(data_mem_write_en_o), 0);
    chk("both_stall_end", 32'(stall_pipeline_o), 0);
    @(negedge risc_clk);
    chk("both_load_dropped", 32'(data_mem_read_en_o), 0);
    chk("both_no_wb", 32'(reg_wr_en_o), 0);

    // Load to x0: WB cycle occupied without a write
    req(1, 0, 32'h3000, 12'h001, 2'b00, 0, 0, 5'd0);
    @(negedge risc_clk); drop_req();
    chk("x0_rd_en", 32'(data_mem_read_en_o), 1);
    @(negedge risc_clk);
    data_mem_rvalid_i = 1'b1; data_mem_read_data_i = 32'h0000_AB00;
    @(negedge risc_clk); data_mem_rvalid_i = 1'b0;
    chk("x0_no_wr", 32'(reg_wr_en_o), 0);
    chk("x0_wb_stall", 32'(stall_pipeline_o), 1);
    @(negedge risc_clk);
    chk("x0_stall_end", 32'(stall_pipeline_o), 0);
    chk("x0_no_wr2", 32'(reg_wr_en_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
